rf_dump_ctrl: RTL and testbench

Run-and-dump controller for the RISC-V core. Sits between the board/top level and the core:
- On a `start_btn` rising edge it enables the core for a programmable number of cycles, or until the core reports halt.
- It then reads every architectural register through a read port and streams the values out over a valid/ready channel.
- This replaces fixed-delay, bench-only register printing with a synthesizable, parametrised mechanism usable on hardware (UART/LED readout) and in simulation.

---
 rtl/rf_dump_ctrl.sv | 151 +++++++++++++++
 tb/tb_rf_dump_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: runs the core for a set number of cycles (or until halt), then streams out every register.
// Latency: core_run one cycle after the start edge; first dump word two cycles after RUN ends; 2 cycles/word minimum.
// Backpressure: dump_valid holds with dump_idx/dump_data frozen until dump_ready; no ready->valid comb path.
//
// Ports: clk/rst (sync, active-high) | start_btn, run_cycles, halt : run control
//        core_run : core enable      | rf_raddr -> rf_rdata : combinational register-file read
//        dump_valid/dump_ready, dump_idx, dump_data : output word stream | busy, done : status
// Optional macro RF_DUMP_CYCLE_COUNT_EN: appends a trailing word (idx NREGS) carrying the RUN cycle
// count; needs ADDR_W wide enough to hold NREGS.
module rf_dump_ctrl #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int ADDR_W  = 5,
  parameter int CYCLE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic [CYCLE_W-1:0] run_cycles,
  input  logic               halt,
  output logic               core_run,
  output logic [ADDR_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [ADDR_W-1:0]  dump_idx,
  output logic [DATA_W-1:0]  dump_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FETCH, S_OUT, S_DONE} state_t;

`ifdef RF_DUMP_CYCLE_COUNT_EN
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS);
`else
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
`endif

  state_t              state_q;
  logic                start_q;
  logic [CYCLE_W-1:0]  cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                core_run_q;
  logic                dump_valid_q;
  logic [ADDR_W-1:0]   dump_idx_q;
  logic [DATA_W-1:0]   dump_data_q;
  logic                busy_q;
  logic                done_q;
`ifdef RF_DUMP_CYCLE_COUNT_EN
  logic [CYCLE_W-1:0]  elapsed_q;
`endif

  logic start_edge;
  assign start_edge = start_btn & ~start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      core_run_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef RF_DUMP_CYCLE_COUNT_EN
      elapsed_q    <= '0;
`endif
    end else begin
      start_q <= start_btn;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            cnt_q  <= run_cycles;
            idx_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
`ifdef RF_DUMP_CYCLE_COUNT_EN
            elapsed_q <= '0;
`endif
            // A zero run length skips the core entirely and dumps straight away.
            if (run_cycles == '0) begin
              state_q <= S_FETCH;
            end else begin
              state_q    <= S_RUN;
              core_run_q <= 1'b1;
            end
          end
        end

        S_RUN: begin
          cnt_q <= cnt_q - CYCLE_W'(1);
`ifdef RF_DUMP_CYCLE_COUNT_EN
          if (elapsed_q != '1) elapsed_q <= elapsed_q + CYCLE_W'(1);
`endif
          // The halt cycle itself still counts as a run cycle.
          if (cnt_q == CYCLE_W'(1) || halt) begin
            state_q    <= S_FETCH;
            core_run_q <= 1'b0;
          end
        end

        S_FETCH: begin
          dump_data_q  <= rf_rdata;
          dump_idx_q   <= idx_q;
          dump_valid_q <= 1'b1;
          state_q      <= S_OUT;
        end

        S_OUT: begin
          if (dump_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= S_DONE;
              dump_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end
`ifdef RF_DUMP_CYCLE_COUNT_EN
            // Cycle-count word needs no register read, so it is loaded without leaving OUT.
            else if (idx_q == ADDR_W'(NREGS - 1)) begin
              idx_q       <= LAST_IDX;
              dump_idx_q  <= LAST_IDX;
              dump_data_q <= DATA_W'(elapsed_q);
            end
`endif
            else begin
              idx_q        <= idx_q + ADDR_W'(1);
              dump_valid_q <= 1'b0;
              state_q      <= S_FETCH;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // idx only changes on the edge into FETCH, so it is a stable registered read address.
  assign rf_raddr   = idx_q;
  assign core_run   = core_run_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Bench for rf_dump_ctrl: builds the expected per-cycle timeline of every run from the start cycle,
// run length, and the pre-drawn dump_ready schedule, then checks the DUT against it each cycle.
module tb_rf_dump_ctrl;
  localparam int DATA_W  = 32;
  localparam int NREGS   = 32;
  localparam int CYCLE_W = 16;
`ifdef RF_DUMP_CYCLE_COUNT_EN
  localparam int ADDR_W = 6;
  localparam int EXTRA  = 1;
`else
  localparam int ADDR_W = 5;
  localparam int EXTRA  = 0;
`endif
  localparam int NW   = NREGS + EXTRA;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start_btn, halt, dump_ready;
  logic [CYCLE_W-1:0] run_cycles;
  logic               core_run, dump_valid, busy, done;
  logic [ADDR_W-1:0]  rf_raddr, dump_idx;
  logic [DATA_W-1:0]  rf_rdata, dump_data;

  logic [DATA_W-1:0] rf_mem [0:(1<<ADDR_W)-1];
  assign rf_rdata = rf_mem[rf_raddr];

  rf_dump_ctrl #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .CYCLE_W(CYCLE_W)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .run_cycles(run_cycles), .halt(halt),
    .core_run(core_run), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cur_c = 0;
  bit chk_en = 0, chk_done = 0, chk_word = 0, chk_raddr = 0;
  logic              exp_run, exp_busy, exp_done, exp_valid;
  logic [ADDR_W-1:0] exp_idx, exp_raddr;
  logic [DATA_W-1:0] exp_data;
  bit rdy_sched [MAXC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cur_c, act, exp);
    end
  endtask

  // Single compare process: outputs are registered, so sample mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("core_run", 64'(core_run), 64'(exp_run));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("dump_valid", 64'(dump_valid), 64'(exp_valid));
      if (chk_done)  chk("done", 64'(done), 64'(exp_done));
      if (chk_word)  chk("dump_idx", 64'(dump_idx), 64'(exp_idx));
      if (chk_word)  chk("dump_data", 64'(dump_data), 64'(exp_data));
      if (chk_raddr) chk("rf_raddr", 64'(rf_raddr), 64'(exp_raddr));
    end
  end

  task automatic set_zero();
    exp_run = 0; exp_busy = 0; exp_done = 0; exp_valid = 0;
    exp_idx = '0; exp_data = '0; exp_raddr = '0;
    chk_done = 1; chk_word = 1; chk_raddr = 1; chk_en = 1;
  endtask

  task automatic fill_rf(input logic [DATA_W-1:0] base, input bit rnd);
    for (int i = 0; i < (1 << ADDR_W); i++)
      rf_mem[i] = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
  endtask

  // Relative cycle 0 is the cycle start_btn rises. Word k is valid from v[k] to its accept cycle a[k];
  // a register fetch occupies the cycle before v[k]; the cycle-count word follows its predecessor directly.
  task automatic run_test(input int rc, input int halt_at, input int rdy_pct, input bit hold_start,
                          input int glitch_word, input int abort_word,
                          output int L, output int v0, output int last_c);
    int v [NW];
    int a [NW];
    int vc, ac, end_c, gc;
    L = (halt_at >= 1 && halt_at <= rc) ? halt_at : rc;
    for (int c = 0; c < MAXC; c++)
      rdy_sched[c] = (c > 1200) || ($urandom_range(99) < rdy_pct);
    vc = L + 2;
    for (int k = 0; k < NW; k++) begin
      v[k] = vc;
      ac = vc;
      while (ac < MAXC - 1 && !rdy_sched[ac]) ac++;
      a[k] = ac;
      vc = (k + 1 >= NREGS) ? ac + 1 : ac + 2;
    end
    v0 = v[0];
    last_c = a[NW-1];
    end_c = (abort_word >= 0) ? v[abort_word] : last_c + 3;
    gc = (glitch_word >= 0) ? v[glitch_word] + 1 : -10;

    for (int c = -1; c <= end_c; c++) begin
      @(posedge clk); #1;
      cur_c = c;
      start_btn  = (c == 0) || (hold_start && c >= 0) || (c == gc);
      run_cycles = (c == 0) ? CYCLE_W'(rc) : CYCLE_W'($urandom);
      halt       = (halt_at > 0 && c == halt_at);
      dump_ready = (c >= 0) ? rdy_sched[c] : 1'b0;
      rst        = (abort_word >= 0 && c == end_c);
      chk_en   = (c >= 0);
      chk_done = (c >= 1);
      exp_run  = (c >= 1 && c <= L);
      exp_busy = (c >= 1 && c <= last_c);
      exp_done = (c > last_c);
      exp_valid = 0; chk_word = 0; chk_raddr = 0;
      exp_idx = '0; exp_data = '0; exp_raddr = '0;
      for (int k = 0; k < NW; k++) begin
        if (c >= v[k] && c <= a[k]) begin
          exp_valid = 1;
          chk_word  = 1;
          exp_idx   = ADDR_W'(k);
          exp_data  = (k < NREGS) ? rf_mem[k] : DATA_W'(L);
        end
        if (k < NREGS && c == v[k] - 1) begin
          chk_raddr = 1;
          exp_raddr = ADDR_W'(k);
        end
      end
    end

    if (abort_word >= 0) begin
      @(posedge clk); #1;
      rst = 0; start_btn = 0; halt = 0;
      cur_c = end_c + 1;
      set_zero();
      @(negedge clk);
    end
    chk_en = 0;
  endtask

  int L, v0, lc;

  initial begin
    rst = 1; start_btn = 1; halt = 0; dump_ready = 0; run_cycles = CYCLE_W'(5);
    fill_rf(DATA_W'(32'h1000), 0);
    cur_c = 0;

    // Reset held for three edges with start_btn high; outputs must stay cleared throughout.
    @(posedge clk); #1;
    set_zero();
    @(posedge clk);
    @(posedge clk); #1;
    start_btn = 0; rst = 0;
    repeat (5) @(posedge clk);
    #1 chk_en = 0;

    // Fixed run of 10, all-ready dump; start_btn stays high so DONE must not restart.
    run_test(10, 0, 100, 1, -1, -1, L, v0, lc);
    chk("pin_len10", 64'(L), 64'd10);
    chk("pin_first_valid10", 64'(v0), 64'd12);
`ifdef RF_DUMP_CYCLE_COUNT_EN
    chk("pin_last_accept10", 64'(lc), 64'd75);
`else
    chk("pin_last_accept10", 64'(lc), 64'd74);
`endif

    // Early halt on the 7th run cycle.
    fill_rf('0, 1);
    run_test(500, 7, 100, 0, -1, -1, L, v0, lc);
    chk("pin_len_halt", 64'(L), 64'd7);
    chk("pin_first_valid_halt", 64'(v0), 64'd9);

    // Heavy backpressure.
    fill_rf('0, 1);
    run_test(25, 0, 30, 0, -1, -1, L, v0, lc);

    // Zero length, stray halt during the dump, start edge mid-dump.
    fill_rf(DATA_W'(32'hA500_0000), 0);
    run_test(0, 3, 100, 0, 5, -1, L, v0, lc);
    chk("pin_len0", 64'(L), 64'd0);
    chk("pin_first_valid0", 64'(v0), 64'd2);

    // Restart from DONE.
    run_test(3, 0, 70, 0, -1, -1, L, v0, lc);

    // Reset while word 12 is on the output, then a full clean run.
    fill_rf('0, 1);
    run_test(5, 0, 60, 0, -1, 12, L, v0, lc);
    run_test(4, 0, 100, 0, -1, -1, L, v0, lc);
    chk("pin_first_valid4", 64'(v0), 64'd6);

    for (int t = 0; t < 4; t++) begin
      fill_rf('0, 1);
      run_test(int'($urandom_range(30)), int'($urandom_range(35)), int'($urandom_range(100, 20)),
               0, int'($urandom_range(NREGS - 1)), -1, L, v0, lc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
